// File: rtl/serial_negator_if.sv
// Handshake bundle for the bit-serial two's-complement negator.
// Optional macro SERIAL_NEGATOR_OVF_EN adds the ovf status line.
interface serial_negator_if;
  logic start;
  logic in_bit;
  logic in_valid;
  logic out_bit;
  logic out_valid;
  logic busy;
  logic done;
`ifdef SERIAL_NEGATOR_OVF_EN
  logic ovf;

  modport master (output start, in_bit, in_valid,
                  input  out_bit, out_valid, busy, done, ovf);
  modport slave  (input  start, in_bit, in_valid,
                  output out_bit, out_valid, busy, done, ovf);
`else
  modport master (output start, in_bit, in_valid,
                  input  out_bit, out_valid, busy, done);
  modport slave  (input  start, in_bit, in_valid,
                  output out_bit, out_valid, busy, done);
`endif
endinterface

// File: rtl/serial_negator.sv
// Bit-serial two's-complement negator, LSB first: copies bits up to and
// including the first 1, inverts every bit after it.
// Optional macro SERIAL_NEGATOR_OVF_EN adds ovf, flagging the most-negative
// operand (its negation is not representable).
//
// state | meaning
// IDLE  | waiting for start; in_valid ignored
// RUN   | accepting operand bits, one result bit per accepted bit
// DONE  | one-cycle done pulse, coincident with the last result bit
module serial_negator #(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  serial_negator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bitCnt;
  logic             seenOne;
  logic             outBit;
  logic             outValid;
  logic             busyQ;
  logic             doneQ;
`ifdef SERIAL_NEGATOR_OVF_EN
  logic             ovfQ;
`endif

  // Sequencer plus registered result path; every output is a flop so the
  // last out_valid and done leave the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      seenOne  <= 1'b0;
      outBit   <= 1'b0;
      outValid <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
`ifdef SERIAL_NEGATOR_OVF_EN
      ovfQ     <= 1'b0;
`endif
    end else begin
      outValid <= 1'b0;
      doneQ    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            bitCnt  <= '0;
            seenOne <= 1'b0;
            busyQ   <= 1'b1;
`ifdef SERIAL_NEGATOR_OVF_EN
            ovfQ    <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            outValid <= 1'b1;
            outBit   <= bus.in_bit ^ seenOne;
            if (bus.in_bit) seenOne <= 1'b1;
            bitCnt   <= bitCnt + CNT_W'(1);
            if (bitCnt == LAST_IDX) begin
              state <= DONE;
              busyQ <= 1'b0;
              doneQ <= 1'b1;
`ifdef SERIAL_NEGATOR_OVF_EN
              // MSB=1 with no earlier 1 means the operand was the most-negative value
              ovfQ  <= bus.in_bit & ~seenOne;
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_bit   = outBit;
  assign bus.out_valid = outValid;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
`ifdef SERIAL_NEGATOR_OVF_EN
  assign bus.ovf       = ovfQ;
`endif

endmodule
